// File: rtl/fifo_level_top.sv
// fifo_level_top: single-clock FIFO with registered-read RAM, occupancy count, thresholds, flush and read-valid strobe
// Ports: clk, rst_n (async active-low); fifo_clear flushes pointers/count on the next edge;
//   fifo_write_req/fifo_write_data push; fifo_read_req pops, data appears on fifo_read_data with
//   fifo_read_valid one cycle later; fifo_full/empty/almost_full/almost_empty and fifo_count are
//   decoded from the registered count; fifo_overflow/fifo_underflow are sticky error flags.
// Optional: define FIFO_ERR_FLAG_EN to build the sticky error flags; otherwise they are tied to 0.
module fifo_level_top #(
  parameter int WIDTH         = 8,
  parameter int DEPTH_LOG     = 8,
  parameter int AFULL_THRESH  = 2**DEPTH_LOG - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_clear,
  input  logic                 fifo_write_req,
  input  logic [WIDTH-1:0]     fifo_write_data,
  input  logic                 fifo_read_req,
  output logic [WIDTH-1:0]     fifo_read_data,
  output logic                 fifo_read_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 fifo_almost_full,
  output logic                 fifo_almost_empty,
  output logic [DEPTH_LOG:0]   fifo_count,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow
);
  localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [DEPTH_LOG:0] AF_CNT   = AFULL_THRESH[DEPTH_LOG:0];
  localparam logic [DEPTH_LOG:0] AE_CNT   = AEMPTY_THRESH[DEPTH_LOG:0];
  logic [WIDTH-1:0]   mem [2**DEPTH_LOG];
  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, wr_acc, rd_acc;
  assign fifo_full         = count_q == FULL_CNT;
  assign fifo_empty        = count_q == '0;
  assign fifo_almost_full  = count_q >= AF_CNT;
  assign fifo_almost_empty = count_q <= AE_CNT;
  assign fifo_count        = count_q;
  assign fifo_read_data    = rd_data_q;
  assign fifo_read_valid   = rd_valid_q;
  assign wr_acc = fifo_write_req & ~fifo_full & ~fifo_clear;
  assign rd_acc = fifo_read_req & ~fifo_empty & ~fifo_clear;
  always_comb begin
    wr_ptr_d  = fifo_clear ? '0 : wr_ptr_q + {{DEPTH_LOG{1'b0}}, wr_acc};
    rd_ptr_d  = fifo_clear ? '0 : rd_ptr_q + {{DEPTH_LOG{1'b0}}, rd_acc};
    count_d   = fifo_clear ? '0 :
                (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    rd_data_d = rd_acc ? mem[rd_ptr_q[DEPTH_LOG-1:0]] : rd_data_q;
  end
  // Storage is not reset; only the pointers define which words are live.
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr_q[DEPTH_LOG-1:0]] <= fifo_write_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_acc;
    end
`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d, udf_q, udf_d;
  always_comb begin
    ovf_d = fifo_clear ? 1'b0 : ovf_q | (fifo_write_req & fifo_full);
    udf_d = fifo_clear ? 1'b0 : udf_q | (fifo_read_req & fifo_empty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = udf_q;
`else
  assign fifo_overflow  = 1'b0;
  assign fifo_underflow = 1'b0;
`endif
endmodule

// File: doc/fifo_level_top.md
# fifo_level_top

Parametrised synchronous FIFO: the next generation of the team's control-plus-dual-port-RAM FIFO. It adds a registered occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and a read-valid strobe. It sits between a single-clock producer and consumer wherever back-pressure needs early warning, and it stores data in the team's registered-read dual-port RAM.

## Interface
- WIDTH, 8: data width in bits.
- DEPTH_LOG, 8: log2 of capacity; the FIFO holds exactly 2^DEPTH_LOG words.
- AFULL_THRESH, 2^DEPTH_LOG-4: almost-full threshold; legal range 1..2^DEPTH_LOG.
- AEMPTY_THRESH, 4: almost-empty threshold; legal range 0..2^DEPTH_LOG-1.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_clear  in  1  synchronous flush.
- fifo_write_req  in  1  write request.
- fifo_write_data  in  WIDTH  write data.
- fifo_read_req  in  1  read request.
- fifo_read_data  out  WIDTH  read data; registered.
- fifo_read_valid  out  1  fifo_read_data is valid this cycle.
- fifo_full, fifo_empty  out  1 each  capacity status.
- fifo_almost_full, fifo_almost_empty  out  1 each  threshold status.
- fifo_count  out  DEPTH_LOG+1  occupancy, 0..2^DEPTH_LOG.
- fifo_overflow, fifo_underflow  out  1 each  sticky error flags (see Configuration).

## Operation
- Pointers: write and read pointers are DEPTH_LOG+1 bits wide. The low DEPTH_LOG bits address the RAM. Pointers wrap modulo 2^(DEPTH_LOG+1) with no special case.
- Write accept: wr_acc = fifo_write_req & ~fifo_full & ~fifo_clear. On accept, the RAM is written at wr_ptr and wr_ptr increments.
- Read accept: rd_acc = fifo_read_req & ~fifo_empty & ~fifo_clear. On accept, the RAM is read at rd_ptr and rd_ptr increments.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both a write and a read are accepted.
- Simultaneous requests:
  - When full, the write is rejected and the read is accepted; count drops by 1.
  - When empty, the write is accepted and the read is rejected; count rises by 1.
- Status flags are decoded combinationally from the registered count:
  - fifo_full = (count == 2^DEPTH_LOG).
  - fifo_empty = (count == 0).
  - fifo_almost_full = (count >= AFULL_THRESH).
  - fifo_almost_empty = (count <= AEMPTY_THRESH).
- fifo_clear: takes priority over both requests. On the next edge, pointers and count go to 0. RAM contents are not erased. A read accepted in the cycle before fifo_clear still delivers its data.
- Rejected requests have no effect on pointers, count or RAM.

## Timing
- Reset values (async assert, sync deassert by the upstream reset synchroniser):
  - count = 0, pointers = 0.
  - fifo_empty = 1, fifo_almost_empty = 1.
  - fifo_full = 0, fifo_almost_full = 0.
  - fifo_read_valid = 0, fifo_read_data = 0.
  - fifo_overflow = 0, fifo_underflow = 0.
- Read latency is 1 cycle. Read accepted at edge N gives fifo_read_valid = 1 with the data during cycle N+1. fifo_read_valid is 0 in every other cycle.
- While fifo_read_valid = 0, fifo_read_data holds its last value.
- Status and count reflect all accepts up to the previous edge. A word written at edge N is readable by a request sampled at edge N+1.
- Back-to-back reads every cycle give one word per cycle.
- Reset mid-operation: every register returns to its reset value immediately, and in-flight read data is discarded.

## Configuration
- FIFO_ERR_FLAG_EN defined:
  - fifo_overflow sets when fifo_write_req & fifo_full & ~fifo_clear.
  - fifo_underflow sets when fifo_read_req & fifo_empty & ~fifo_clear.
  - Both are sticky, set the cycle after the event, and clear only on fifo_clear or rst_n.
- FIFO_ERR_FLAG_EN not defined: both ports remain present and are tied to 0; no error logic is synthesised.

## Test plan
All scenarios use WIDTH=8, DEPTH_LOG=2, AFULL_THRESH=3, AEMPTY_THRESH=1.
- Fill and drain: write 0x11,0x22,0x33,0x44 on consecutive cycles, then read 4 times.
  - During the fill, count goes 1,2,3,4; almost_full rises at count 3 and full at 4.
  - On the drain, read_valid is high for 4 cycles with data 0x11,0x22,0x33,0x44; empty = 1 after.
- Simultaneous at boundaries:
  - Full, write+read in one cycle: count goes 4→3 and the written word is dropped.
  - Empty, write+read in one cycle: count goes 0→1 and read_valid stays 0.
- Wrap-around: 10 write/read pairs with data 0x00..0x09, count held at 1–2. The output sequence is 0x00..0x09, in order, with no gaps.
- Flush: with count=3, assert fifo_clear together with write_req and read_req.
  - Next cycle: count = 0, empty = 1, read_valid = 0.
  - A subsequent write of 0xA5 reads back as 0xA5.
- Errors (FIFO_ERR_FLAG_EN defined): write while full sets overflow; read while empty sets underflow. Both hold through 5 idle cycles and clear one cycle after fifo_clear. With the macro undefined, both read 0 throughout.
- Async reset at count=2 with a read in flight: all outputs take their reset values the same cycle, and read_valid stays 0 afterwards.
